// File: rtl/exe_stage_pkg.sv
// Shared constants, bundle layouts and helpers for the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 145;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int STUCK_BUS_WD    = 38;
  localparam int ALU_OP_WD       = 12;

  // One-hot bit positions of the ALU operation code.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Decode-to-execute bundle, most significant field first.
  typedef struct packed {
    logic                 mfhi;
    logic                 mflo;
    logic                 mthi;
    logic                 mtlo;
    logic                 divu;
    logic                 div;
    logic                 multu;
    logic                 mult;
    logic                 src2_ze_imm;
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_sa;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_8;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [15:0]          imm;
    logic [31:0]          rs_value;
    logic [31:0]          rt_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when cond is set.
  function automatic logic [31:0] neg_if(input logic cond, input logic [31:0] val);
    logic [31:0] res;
    if (cond) begin
      res = ~val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider: 32 shift/subtract steps on operand magnitudes,
// sign fix-up applied on the output side.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        sign_mode,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  div_state_e  state_r;
  logic [4:0]  cnt_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dsr_r;

  logic [31:0] dividend_abs_s;
  logic [31:0] divisor_abs_s;
  logic [32:0] rem_shift_s;
  logic        sub_ok_s;
  logic [31:0] diff_s;
  logic [31:0] rem_next_s;
  logic        div_zero_s;

  // Operand magnitudes and one restoring step of the shift/subtract datapath.
  always_comb begin
    dividend_abs_s = neg_if(sign_mode & dividend[31], dividend);
    divisor_abs_s  = neg_if(sign_mode & divisor[31], divisor);
    rem_shift_s    = {rem_r, quo_r[31]};
    sub_ok_s       = (rem_shift_s >= {1'b0, dsr_r});
    diff_s         = rem_shift_s[31:0] - dsr_r;
    if (sub_ok_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = rem_shift_s[31:0];
    end
  end

  // Divider FSM: latch magnitudes, run 32 steps, hold result until the instruction retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= DIV_IDLE;
      cnt_r   <= 5'd0;
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dsr_r   <= 32'd0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            quo_r   <= dividend_abs_s;
            rem_r   <= 32'd0;
            dsr_r   <= divisor_abs_s;
            cnt_r   <= 5'd0;
            state_r <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          quo_r <= {quo_r[30:0], sub_ok_s};
          rem_r <= rem_next_s;
          if (cnt_r == 5'd31) begin
            state_r <= DIV_DONE;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        DIV_DONE: begin
          if (ack) begin
            state_r <= DIV_IDLE;
          end
        end
        default: state_r <= DIV_IDLE;
      endcase
    end
  end

  // Divisor zero yields all-ones quotient and the raw dividend; otherwise apply sign rules.
  // The operand inputs come from the held stage bundle, so they are stable while DONE.
  always_comb begin
    div_zero_s = (dsr_r == 32'd0);
    if (div_zero_s) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = dividend;
    end else begin
      quotient  = neg_if(sign_mode & (dividend[31] ^ divisor[31]), quo_r);
      remainder = neg_if(sign_mode & dividend[31], rem_r);
    end
  end

  assign done = (state_r == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand selection, ALU, HI/LO with multiply/divide, data SRAM
// request, memory-stage bundle and forwarding bus back to decode.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = exe_stage_pkg::DS_TO_ES_BUS_WD,
  parameter int ES_TO_MS_BUS_WD = exe_stage_pkg::ES_TO_MS_BUS_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [37:0]                stuck_es_to_ds_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  import exe_stage_pkg::*;

  logic        es_valid_r;
  ds_to_es_t   es_bus_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        is_div_s;
  logic        div_done_s;
  logic        es_ready_go_s;
  logic        es_leave_s;
  logic        div_start_s;
  logic [31:0] src1_s;
  logic [31:0] src2_s;
  logic [31:0] alu_result_s;
  logic [31:0] es_result_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] mul_prod_s;
  logic [31:0] add_sub_s;
  logic [31:0] sra_s;
  logic        slt_s;
  logic        sltu_s;

  assign is_div_s       = es_bus_r.div | es_bus_r.divu;
  assign es_ready_go_s  = is_div_s ? div_done_s : 1'b1;
  assign es_allowin     = !es_valid_r || (es_ready_go_s && ms_allowin);
  assign es_to_ms_valid = es_valid_r && es_ready_go_s;
  assign es_leave_s     = es_to_ms_valid && ms_allowin;
  assign div_start_s    = es_valid_r && is_div_s;

  // Stage occupancy follows the upstream valid whenever this stage can accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_r <= 1'b0;
    end else if (es_allowin) begin
      es_valid_r <= ds_to_es_valid;
    end
  end

  // Bundle register captures the decode bundle only on an accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_bus_r <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      es_bus_r <= ds_to_es_bus;
    end
  end

  // Operand selection for the ALU.
  always_comb begin
    if (es_bus_r.src1_is_sa) begin
      src1_s = {27'd0, es_bus_r.imm[10:6]};
    end else if (es_bus_r.src1_is_pc) begin
      src1_s = es_bus_r.pc;
    end else begin
      src1_s = es_bus_r.rs_value;
    end
    if (es_bus_r.src2_is_imm) begin
      src2_s = {{16{es_bus_r.imm[15]}}, es_bus_r.imm};
    end else if (es_bus_r.src2_ze_imm) begin
      src2_s = {16'd0, es_bus_r.imm};
    end else if (es_bus_r.src2_is_8) begin
      src2_s = 32'd8;
    end else begin
      src2_s = es_bus_r.rt_value;
    end
  end

  // One-hot ALU: each operation is masked by its op bit and the results OR-ed.
  always_comb begin
    if (es_bus_r.alu_op[ALU_ADD]) begin
      add_sub_s = src1_s + src2_s;
    end else begin
      add_sub_s = src1_s - src2_s;
    end
    slt_s  = ($signed(src1_s) < $signed(src2_s));
    sltu_s = (src1_s < src2_s);
    sra_s  = $unsigned($signed(src2_s) >>> src1_s[4:0]);
    alu_result_s = ({32{es_bus_r.alu_op[ALU_ADD] | es_bus_r.alu_op[ALU_SUB]}} & add_sub_s)
                 | ({32{es_bus_r.alu_op[ALU_SLT]}}  & {31'd0, slt_s})
                 | ({32{es_bus_r.alu_op[ALU_SLTU]}} & {31'd0, sltu_s})
                 | ({32{es_bus_r.alu_op[ALU_AND]}}  & (src1_s & src2_s))
                 | ({32{es_bus_r.alu_op[ALU_NOR]}}  & ~(src1_s | src2_s))
                 | ({32{es_bus_r.alu_op[ALU_OR]}}   & (src1_s | src2_s))
                 | ({32{es_bus_r.alu_op[ALU_XOR]}}  & (src1_s ^ src2_s))
                 | ({32{es_bus_r.alu_op[ALU_SLL]}}  & (src2_s << src1_s[4:0]))
                 | ({32{es_bus_r.alu_op[ALU_SRL]}}  & (src2_s >> src1_s[4:0]))
                 | ({32{es_bus_r.alu_op[ALU_SRA]}}  & sra_s)
                 | ({32{es_bus_r.alu_op[ALU_LUI]}}  & {src2_s[15:0], 16'd0});
  end

  // A single 64x64 multiplier: sign-extending for mult gives the signed product in the low 64 bits.
  always_comb begin
    mul_a_s    = {{32{es_bus_r.mult & es_bus_r.rs_value[31]}}, es_bus_r.rs_value};
    mul_b_s    = {{32{es_bus_r.mult & es_bus_r.rt_value[31]}}, es_bus_r.rt_value};
    mul_prod_s = mul_a_s * mul_b_s;
  end

  div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start_s),
    .ack       (es_leave_s),
    .sign_mode (es_bus_r.div),
    .dividend  (es_bus_r.rs_value),
    .divisor   (es_bus_r.rt_value),
    .quotient  (quot_s),
    .remainder (rem_s),
    .done      (div_done_s)
  );

  // HI/LO commit only as the owning instruction leaves the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (es_leave_s) begin
      if (es_bus_r.mthi) begin
        hi_r <= es_bus_r.rs_value;
      end else if (es_bus_r.mult | es_bus_r.multu) begin
        hi_r <= mul_prod_s[63:32];
      end else if (is_div_s) begin
        hi_r <= rem_s;
      end
      if (es_bus_r.mtlo) begin
        lo_r <= es_bus_r.rs_value;
      end else if (es_bus_r.mult | es_bus_r.multu) begin
        lo_r <= mul_prod_s[31:0];
      end else if (is_div_s) begin
        lo_r <= quot_s;
      end
    end
  end

  // Stage result: HI/LO moves override the ALU.
  always_comb begin
    if (es_bus_r.mfhi) begin
      es_result_s = hi_r;
    end else if (es_bus_r.mflo) begin
      es_result_s = lo_r;
    end else begin
      es_result_s = alu_result_s;
    end
  end

  assign es_to_ms_bus = {es_bus_r.load_op, es_bus_r.gr_we, es_bus_r.dest, es_result_s, es_bus_r.pc};

  assign stuck_es_to_ds_bus = {es_valid_r && es_bus_r.load_op,
                               (es_valid_r && es_bus_r.gr_we) ? es_bus_r.dest : 5'd0,
                               es_result_s};

  assign data_sram_en    = es_valid_r;
  assign data_sram_wen   = (es_valid_r && es_bus_r.mem_we) ? 4'hF : 4'h0;
  assign data_sram_addr  = alu_result_s;
  assign data_sram_wdata = es_bus_r.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected memory-stage bundles,
// a monitor pops and compares them whenever the stage hands one over.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [144:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [37:0]  stuck_es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int           compared = 0;
  int           mismatched = 0;
  logic [70:0]  exp_q[$];
  logic [31:0]  pc_v = 32'hBFC0_0000;

  exe_stage dut (
    .clk                (clk),
    .reset              (reset),
    .ms_allowin         (ms_allowin),
    .es_allowin         (es_allowin),
    .ds_to_es_valid     (ds_to_es_valid),
    .ds_to_es_bus       (ds_to_es_bus),
    .es_to_ms_valid     (es_to_ms_valid),
    .es_to_ms_bus       (es_to_ms_bus),
    .stuck_es_to_ds_bus (stuck_es_to_ds_bus),
    .data_sram_en       (data_sram_en),
    .data_sram_wen      (data_sram_wen),
    .data_sram_addr     (data_sram_addr),
    .data_sram_wdata    (data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handed-over bundle must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && es_to_ms_valid && ms_allowin) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got %h, expected none", es_to_ms_bus);
      end else begin
        check("es_to_ms_bus", es_to_ms_bus, exp_q.pop_front());
      end
    end
  end

  function automatic ds_to_es_t mk();
    ds_to_es_t b;
    b    = '0;
    b.pc = pc_v;
    pc_v = pc_v + 32'd4;
    return b;
  endfunction

  // Present one bundle and wait (bounded) until it is accepted.
  task automatic send(input ds_to_es_t b, input logic push, input logic ld, input logic we,
                      input logic [4:0] dst, input logic [31:0] res);
    int n;
    n = 0;
    ds_to_es_bus   = b;
    ds_to_es_valid = 1'b1;
    if (push) exp_q.push_back({ld, we, dst, res, b.pc});
    @(negedge clk);
    while (!es_allowin && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got allowin stuck low, expected accept");
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic move_hilo(input logic to_hi, input logic [31:0] v);
    ds_to_es_t b;
    b = mk();
    b.mthi = to_hi;
    b.mtlo = !to_hi;
    b.rs_value = v;
    send(b, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    ds_to_es_t b;
    b = mk();
    b.mfhi = 1'b1; b.gr_we = 1'b1; b.dest = 5'd7;
    send(b, 1'b1, 1'b0, 1'b1, 5'd7, exp_hi);
    b = mk();
    b.mflo = 1'b1; b.gr_we = 1'b1; b.dest = 5'd8;
    send(b, 1'b1, 1'b0, 1'b1, 5'd8, exp_lo);
  endtask

  // Issue a divide and measure how long it holds the stage.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] d);
    ds_to_es_t b;
    int n;
    logic bad;
    b = mk();
    b.div = sgn; b.divu = !sgn; b.rs_value = a; b.rt_value = d;
    send(b, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!es_to_ms_valid && n < 100) begin
      if (es_allowin) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("div_latency", 71'(n), 71'(33));
    check("div_allowin_held_low", 71'(bad), 71'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ds_to_es_t b;
    reset = 1'b1;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", 71'(es_allowin), 71'(1));
    check("rst_to_ms_valid", 71'(es_to_ms_valid), 71'(0));
    check("rst_sram_en", 71'(data_sram_en), 71'(0));
    check("rst_sram_wen", 71'(data_sram_wen), 71'(0));
    check("rst_stuck", 71'(stuck_es_to_ds_bus), 71'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addiu: 5 + sext(0xFFFF) = 4
    b = mk();
    b.alu_op = 12'd1 << ALU_ADD; b.src2_is_imm = 1'b1; b.gr_we = 1'b1;
    b.dest = 5'd3; b.imm = 16'hFFFF; b.rs_value = 32'd5;
    send(b, 1'b1, 1'b0, 1'b1, 5'd3, 32'd4);
    @(negedge clk);
    check("addiu_stuck", 71'(stuck_es_to_ds_bus), 71'({1'b0, 5'd3, 32'd4}));
    check("addiu_valid", 71'(es_to_ms_valid), 71'(1));
    idle(1);

    // lw: address 0x1000 + 8
    b = mk();
    b.alu_op = 12'd1 << ALU_ADD; b.src2_is_imm = 1'b1; b.load_op = 1'b1; b.gr_we = 1'b1;
    b.dest = 5'd4; b.imm = 16'd8; b.rs_value = 32'h0000_1000;
    send(b, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_1008);
    @(negedge clk);
    check("lw_addr", 71'(data_sram_addr), 71'(32'h0000_1008));
    check("lw_wen", 71'(data_sram_wen), 71'(0));
    check("lw_en", 71'(data_sram_en), 71'(1));
    check("lw_stuck", 71'(stuck_es_to_ds_bus), 71'({1'b1, 5'd4, 32'h0000_1008}));
    idle(1);

    // sw held for three cycles by the memory stage
    b = mk();
    b.alu_op = 12'd1 << ALU_ADD; b.src2_is_imm = 1'b1; b.mem_we = 1'b1;
    b.imm = 16'h0010; b.rs_value = 32'h0000_2000; b.rt_value = 32'hDEAD_BEEF;
    send(b, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_2010);
    ms_allowin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("sw_wen", 71'(data_sram_wen), 71'(4'hF));
      check("sw_addr", 71'(data_sram_addr), 71'(32'h0000_2010));
      check("sw_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
      check("sw_allowin_low", 71'(es_allowin), 71'(0));
      @(posedge clk);
      #1;
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    check("sw_allowin_release", 71'(es_allowin), 71'(1));
    idle(1);

    // mult -3 * 7 = -21, then read back HI/LO
    b = mk();
    b.mult = 1'b1; b.rs_value = 32'hFFFF_FFFD; b.rt_value = 32'd7;
    send(b, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // divides: signed, unsigned, overflow corner, divide by zero
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div(1'b0, 32'd100, 32'd7);
    read_hilo(32'd2, 32'd14);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo(32'd0, 32'h8000_0000);
    run_div(1'b0, 32'h1234_5678, 32'd0);
    read_hilo(32'h1234_5678, 32'hFFFF_FFFF);
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0);
    read_hilo(32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // mthi/mtlo, then clear both before abandoning a divide with reset
    move_hilo(1'b1, 32'hA5A5_A5A5);
    move_hilo(1'b0, 32'h5A5A_5A5A);
    read_hilo(32'hA5A5_A5A5, 32'h5A5A_5A5A);
    move_hilo(1'b1, 32'd0);
    move_hilo(1'b0, 32'd0);
    b = mk();
    b.div = 1'b1; b.rs_value = 32'd100; b.rt_value = 32'd7;
    send(b, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(9);
    reset = 1'b1;
    #1;
    check("midrst_allowin", 71'(es_allowin), 71'(1));
    check("midrst_to_ms_valid", 71'(es_to_ms_valid), 71'(0));
    check("midrst_sram_en", 71'(data_sram_en), 71'(0));
    check("midrst_sram_wen", 71'(data_sram_wen), 71'(0));
    check("midrst_stuck", 71'(stuck_es_to_ds_bus), 71'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    read_hilo(32'd0, 32'd0);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7);
    read_hilo(32'hFFFF_FFFE, 32'hFFFF_FFF2);

    idle(3);
    check("scoreboard_drained", 71'(exp_q.size()), 71'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between the decode stage and the memory stage.
- Consumes the decode-stage bundle and runs the ALU. Owns the HI/LO registers, a single-cycle multiply and an iterative 32-cycle divider.
- Issues the data-SRAM request and produces the memory-stage bundle.
- Returns a forwarding/stall bus to decode.

Parameters:
- DS_TO_ES_BUS_WD, 145, width of the incoming decode bundle (shared constant).
- ES_TO_MS_BUS_WD, 71, width of the outgoing memory-stage bundle (shared constant).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- ms_allowin  in  1  memory stage can accept.
- es_allowin  out  1  this stage can accept.
- ds_to_es_valid  in  1  decode bundle valid.
- ds_to_es_bus  in  145  {mfhi 144, mflo 143, mthi 142, mtlo 141, divu 140, div 139, multu 138, mult 137, src2_ze_imm 136, alu_op 135:124, load_op 123, src1_is_sa 122, src1_is_pc 121, src2_is_imm 120, src2_is_8 119, gr_we 118, mem_we 117, dest 116:112, imm 111:96, rs_value 95:64, rt_value 63:32, pc 31:0}.
- es_to_ms_valid  out  1  bundle to memory stage valid.
- es_to_ms_bus  out  71  {res_from_mem 70, gr_we 69, dest 68:64, es_result 63:32, pc 31:0}.
- stuck_es_to_ds_bus  out  38  {es_is_load 37, fwd_addr 36:32, fwd_data 31:0}.
- data_sram_en  out  1  data RAM enable.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  data RAM address.
- data_sram_wdata  out  32  store data.

Behaviour:

Handshake
- es_allowin = !es_valid || (es_ready_go && ms_allowin).
- es_to_ms_valid = es_valid && es_ready_go.
- On es_allowin, es_valid <= ds_to_es_valid.
- The bundle register loads only when ds_to_es_valid && es_allowin.
- es_ready_go = 1, except for div/divu, where it is div_done.

Operands
- src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
- src2 = src2_is_imm ? sign-extended imm : src2_ze_imm ? zero-extended imm : src2_is_8 ? 32'd8 : rt_value.
- The team's alu module receives alu_op as a 12-bit one-hot code.

Result
- es_result = mfhi ? HI : mflo ? LO : alu_result.

HI/LO
- Updated only on the cycle the instruction leaves ES (es_to_ms_valid && ms_allowin).
- mthi: HI <= rs_value. mtlo: LO <= rs_value.
- mult/multu: {HI,LO} <= 64-bit signed/unsigned product of rs_value × rt_value.
- div/divu: LO <= quotient, HI <= remainder.

Divider FSM
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY when es_valid && (div||divu). Latch operand magnitudes; counter = 0.
- BUSY: one restoring-shift/subtract step per cycle. After 32 steps -> DONE.
- DONE: div_done = 1. -> IDLE when the instruction leaves ES.
- Latency: ready_go rises 33 cycles after the divide enters ES.
- Signed sign rules: quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
- 0x80000000/-1: quotient 0x80000000, remainder 0.
- Divide by zero (both signed and unsigned): LO = 32'hFFFFFFFF, HI = rs_value. Still takes 33 cycles.

Data SRAM
- data_sram_en = es_valid.
- data_sram_wen = (es_valid && mem_we) ? 4'hF : 4'h0.
- data_sram_addr = alu_result. data_sram_wdata = rt_value.
- A store held by !ms_allowin re-presents the identical write. This is idempotent and permitted.

Forwarding bus
- es_is_load = es_valid && load_op.
- fwd_addr = (es_valid && gr_we) ? dest : 5'd0.
- fwd_data = es_result.
- A divide still in BUSY drives fwd_addr = dest and es_is_load = 0. Decode holds via this stage's es_allowin = 0.

Reset
- Reset is asynchronous and clears: es_valid, bundle register, HI, LO, FSM state (-> IDLE), counter.
- Reset values therefore: es_allowin = 1, es_to_ms_valid = 0, data_sram_en = 0, data_sram_wen = 0, stuck bus = 0.
- Reset during BUSY abandons the divide; HI/LO are not written.

Simultaneous events
- New bundle accepted in the same cycle the previous divide retires: the FSM goes to IDLE first, then starts next cycle if the new instruction is a divide.

Decomposition:
- Shared header (mycpu.h) holds DS_TO_ES_BUS_WD, ES_TO_MS_BUS_WD and the bus field offsets.
- One sub-module: div_iter (start, signed, dividend, divisor -> quotient, remainder, done). It contains the FSM and the 32-step datapath.
- Multiply uses the synthesis operator inline.

Test Plan:
- addiu: rs_value = 5, imm = 16'hFFFF, ms_allowin = 1 -> next cycle es_to_ms_bus es_result = 4; stuck bus addr = dest, data = 4, bit37 = 0.
- lw: rs_value = 0x1000, imm = 8 -> data_sram_addr = 0x1008, wen = 0, en = 1; stuck bus bit37 = 1.
- sw: rt_value = 0xDEADBEEF while ms_allowin = 0 for 3 cycles -> wen = F with constant addr/wdata; es_allowin = 0 until ms_allowin rises.
- mult: rs = -3, rt = 7, then mfhi, then mflo -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- div: rs = -7, rt = 2 -> es_to_ms_valid low for 33 cycles, es_allowin = 0 during them; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu by 0 -> LO = 0xFFFFFFFF, HI = rs.
- Assert reset at cycle 10 of a divide -> outputs go to reset values immediately; HI/LO unchanged; the next divide completes normally.
